gf_poly_eval: RTL
=================

# gf_poly_eval

Multicycle GF(2^m) polynomial evaluator (Horner scheme) for the HQC/BCH decoding path, instantiated as a sibling accelerator in the PQ execute unit and driven by the same enable/ready handshake as the GF multiplier and Chien units. It holds up to 64 coefficients in local registers, evaluates the stored polynomial at a point supplied by the core, and returns the value on `out_1`. The execute unit ANDs `ready` into its stall logic. Its output mux takes `out_1` zero-extended to 32 bits.

## Interface
- `PARAM_M`, 9: field width m; elements are m-bit.
- `PARAM_ALPHA`, 4: reduction polynomial x^m + x^ALPHA + 1.
- `PARAM_LOG_D`, 6: coefficient address width; capacity 2^LOG_D coefficients.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: operation select from the execute-unit decoder. Held high by the core until `ready`=1.
- `in_1` input 32: data operand; coefficient, degree or evaluation point in bits [M-1:0] or [LOG_D-1:0].
- `in_2` input 32: command; opcode in [31:30], coefficient address in [LOG_D-1:0].
- `out_1` output PARAM_M: result.
- `ready` output 1: 0 stalls the core.

## Operation
- Opcodes in `in_2[31:30]`:
  - 00 WRITE: `coef[in_2[LOG_D-1:0]] <= in_1[M-1:0]`. Single-cycle.
  - 01 SETDEG: `deg <= in_1[LOG_D-1:0]`. Single-cycle.
  - 10 EVAL: multicycle. Computes sum of `coef[i]*x^i` for i = 0 to `deg`, with x = `in_1[M-1:0]`.
  - 11 READ: `out_1 = coef[in_2[LOG_D-1:0]]`, combinational. Single-cycle.
- The GF multiply is a combinational full multiply mod x^M + x^ALPHA + 1; addition is XOR. Each RUN cycle performs one Horner step.
- States:
  - IDLE: opcodes are decoded only in IDLE.
    - EVAL: latch x into `xr`, `acc <= coef[deg]`, `cnt <= deg`. Go to DONE if `deg`==0, else RUN.
  - RUN: `acc <= gfmul(acc, xr) ^ coef[cnt-1]`, `cnt <= cnt-1`. Go to DONE when `cnt`==1.
  - DONE: `res <= acc` on entry. Unconditionally return to IDLE next cycle, regardless of `enable`.
- While in RUN/DONE, `enable`, `in_1` and `in_2` are ignored. The held operands are not re-sampled.
- `ready` = 0 when (IDLE & `enable` & opcode==EVAL) or state==RUN; otherwise 1. This is combinational so the core stalls in the accept cycle.
- `out_1`:
  - = `coef[addr]` when IDLE & `enable` & opcode==READ.
  - Otherwise = `acc` in DONE, and the registered `res` elsewhere.
- Back-to-back EVAL: after DONE the FSM returns to IDLE, so a new EVAL held on `enable` starts in the following cycle.
- WRITE to coefficient k during IDLE is visible to the next EVAL.
- Bits of `in_1` above M are ignored.

## Timing
- Reset (async, immediate) clears everything:
  - state=IDLE, `acc`=`res`=`xr`=`cnt`=0, `deg`=0, all `coef`=0.
  - `ready`=1 and `out_1`=0 from the moment `rst` asserts.
- EVAL accepted in cycle T0: `ready`=0 for cycles T0 … T0+`deg`, and `ready`=1 with a valid `out_1` in cycle T0+`deg`+1 (DONE).
  - Total `deg`+1 stall cycles.
  - `deg`=0: one stall cycle; result = `coef[0]`.
- `out_1` retains the last EVAL result until the next EVAL completes or a READ is issued.
- Reset asserted mid-RUN aborts the evaluation. No result is written, and `ready`=1 immediately.
- `deg`=2^LOG_D−1 (63): 64 stall cycles; `cnt` never underflows.
- x=0: result = `coef[0]`. x=1: result = XOR of `coef[0..deg]`.

## Test plan
- Reset: assert `rst` mid-RUN → `ready`=1 and `out_1`=0 within the same cycle. A subsequent READ of any address returns 0.
- Degree 1, no reduction: WRITE c0=0x001, c1=0x001; SETDEG 1; EVAL x=0x002 → `ready` low for 2 cycles, then `out_1`=0x003.
- Reduction: c1=0x100, c0=0; SETDEG 1; EVAL x=0x002 → `out_1`=0x011 (x^9 = x^4 + 1).
- Degree 0 and x=1 edge: SETDEG 0, c0=0x1AB; EVAL any x → 1 stall cycle, `out_1`=0x1AB. Then SETDEG 63, all coef=0x155; EVAL x=1 → 64 stall cycles, `out_1`=0x000 (even count XOR).
- Back-to-back: two EVALs held consecutively with x=2 then x=3 → two separate stall windows separated by one `ready`=1 cycle, each with the correct value. Check against a software Horner model over 500 random (`deg`, `coef`, x) sets.
- READ/WRITE: WRITE addr 63 = 0x1FF, READ addr 63 → `out_1`=0x1FF in the same cycle with `ready`=1. Bits [31:9] of `in_1` are set to garbage and must not affect the result.

Source files
------------

// File: rtl/gf_poly_eval.sv
// rtl/gf_poly_eval.sv - multicycle GF(2^m) Horner polynomial evaluator
// Coefficient store plus an IDLE/RUN/DONE sequencer sharing the execute-unit enable/ready handshake.
module gf_poly_eval #(
  parameter int PARAM_M     = 9,
  parameter int PARAM_ALPHA = 4,
  parameter int PARAM_LOG_D = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [31:0]        in_1,
  input  logic [31:0]        in_2,
  output logic [PARAM_M-1:0] out_1,
  output logic               ready
);

  localparam int M    = PARAM_M;
  localparam int LD   = PARAM_LOG_D;
  localparam int NCOE = 1 << LD;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SETDEG = 2'b01;
  localparam logic [1:0] OP_EVAL   = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  logic [1:0]    r_state;
  logic [M-1:0]  r_coef [NCOE];
  logic [M-1:0]  r_acc;
  logic [M-1:0]  r_res;
  logic [M-1:0]  r_xr;
  logic [LD-1:0] r_cnt;
  logic [LD-1:0] r_deg;

  logic [1:0]    w_op;
  logic [LD-1:0] w_addr;
  logic [M-1:0]  w_data;
  logic          w_idle_en;
  logic [LD-1:0] w_cnt_m1;
  logic [M-1:0]  w_step;
  logic          w_unused;

  // Full carry-less product, then fold bits >= M back using x^M = x^ALPHA + 1.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ ({{(M-1){1'b0}}, a} << i);
    end
    for (int i = 2*M-2; i >= M; i--) begin
      if (p[i]) begin
        p[i]               = 1'b0;
        p[i-M+PARAM_ALPHA] = ~p[i-M+PARAM_ALPHA];
        p[i-M]             = ~p[i-M];
      end
    end
    return p[M-1:0];
  endfunction

  assign w_op      = in_2[31:30];
  assign w_addr    = in_2[LD-1:0];
  assign w_data    = in_1[M-1:0];
  assign w_idle_en = (r_state == S_IDLE) && enable;
  assign w_cnt_m1  = r_cnt - 1'b1;
  assign w_step    = gf_mul(r_acc, r_xr) ^ r_coef[w_cnt_m1];
  assign w_unused  = ^{in_1[31:M], in_2[29:LD]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_res   <= '0;
      r_xr    <= '0;
      r_cnt   <= '0;
      r_deg   <= '0;
      for (int i = 0; i < NCOE; i++) r_coef[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            case (w_op)
              OP_WRITE:  r_coef[w_addr] <= w_data;
              OP_SETDEG: r_deg <= in_1[LD-1:0];
              OP_EVAL: begin
                r_xr    <= w_data;
                r_acc   <= r_coef[r_deg];
                r_cnt   <= r_deg;
                r_state <= (r_deg == '0) ? S_DONE : S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_acc <= w_step;
          r_cnt <= w_cnt_m1;
          if (r_cnt == {{(LD-1){1'b0}}, 1'b1}) r_state <= S_DONE;
        end
        S_DONE: begin
          r_res   <= r_acc;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset forces the idle-looking outputs even while the core still holds an EVAL.
  always_comb begin
    ready = 1'b1;
    if (!rst && ((w_idle_en && (w_op == OP_EVAL)) || (r_state == S_RUN))) ready = 1'b0;
  end

  always_comb begin
    out_1 = r_res;
    if (rst) out_1 = '0;
    else if (w_idle_en && (w_op == OP_READ)) out_1 = r_coef[w_addr];
    else if (r_state == S_DONE) out_1 = r_acc;
  end

endmodule
